spi_bridge: RTL and testbench

Register-access controller that sits behind the `spi` slave and turns consecutive SPI frames into reads and writes on a simple internal bus.
- It decodes a command frame and, for reads, prefetches the register value onto `di` before the next frame starts.
- It latches write data when the data frame ends and runs the bus handshake.
- It enforces an inter-frame timeout and reports protocol faults in a sticky error bit, which the next command frame returns.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_bridge.sv | 132 +++++++++++++
 tb/tb_spi_bridge.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bridge: FSM states and command-word layout.
// Bit positions are counted down from the word MSB so they hold for any SPI word width.
package spi_pkg;

   typedef enum logic [1:0] {
      CMD  = 2'd0,
      RD   = 2'd1,
      DATA = 2'd2,
      WR   = 2'd3
   } state_t;

   localparam int CMD_W        = 0;
   localparam int CMD_ADDR_MSB = 1;

endpackage

// File: rtl/spi_bridge.sv
// Two-frame SPI register bridge: a command frame (W flag + address) followed by a data frame,
// mapped onto a level-request/single-cycle-ack internal bus, with timeout and sticky error.
module spi_bridge
   import spi_pkg::*;
#(
   parameter int size    = 8,
   parameter int timeout = 1024
) (
   input  logic            i_clk,
   input  logic            i_nrst,
   input  logic            i_re,
   input  logic            i_we,
   input  logic [size-1:0] i_do,
   output logic [size-1:0] o_di,
   output logic [size-2:0] o_bus_addr,
   output logic [size-1:0] o_bus_wdata,
   output logic            o_bus_rd,
   output logic            o_bus_wr,
   input  logic [size-1:0] i_bus_rdata,
   input  logic            i_bus_ack,
   output logic            o_err
);

   localparam int W_POS    = size - 1 - CMD_W;
   localparam int ADDR_MSB = size - 1 - CMD_ADDR_MSB;
   localparam int CNT_W    = $clog2(timeout);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [size-1:0]   r_tx;
   logic [size-1:0]   w_tx_nxt;
   logic [size-2:0]   r_bus_addr;
   logic [size-2:0]   w_bus_addr_nxt;
   logic [size-1:0]   r_bus_wdata;
   logic [size-1:0]   w_bus_wdata_nxt;
   logic              r_cmd_w;
   logic              w_cmd_w_nxt;
   logic              r_err;
   logic              w_err_nxt;
   logic              w_err_set;
   logic              w_err_clr;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_timeout;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_state     <= CMD;
         r_tx        <= '0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_cmd_w     <= 1'b0;
         r_err       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_tx        <= w_tx_nxt;
         r_bus_addr  <= w_bus_addr_nxt;
         r_bus_wdata <= w_bus_wdata_nxt;
         r_cmd_w     <= w_cmd_w_nxt;
         r_err       <= w_err_nxt;
         r_cnt       <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_tx_nxt        = r_tx;
      w_bus_addr_nxt  = r_bus_addr;
      w_bus_wdata_nxt = r_bus_wdata;
      w_cmd_w_nxt     = r_cmd_w;
      w_err_set       = 1'b0;
      w_err_clr       = 1'b0;
      w_timeout       = (r_state != CMD) && (r_cnt == CNT_W'(timeout - 1));

      case (r_state)
         CMD: begin
            if (i_we) begin
               w_bus_addr_nxt = i_do[ADDR_MSB:0];
               w_cmd_w_nxt    = i_do[W_POS];
               w_tx_nxt       = '0;
               w_err_clr      = 1'b1;
               w_state_nxt    = i_do[W_POS] ? DATA : RD;
            end
         end
         RD: begin
            // A data frame that starts before the ack has already latched di; abandon the read.
            if (i_re) begin
               w_err_set   = 1'b1;
               w_tx_nxt    = '0;
               w_state_nxt = DATA;
            end else if (i_bus_ack) begin
               w_tx_nxt    = i_bus_rdata;
               w_state_nxt = DATA;
            end
         end
         DATA: begin
            if (i_we) begin
               if (r_cmd_w) begin
                  w_bus_wdata_nxt = i_do;
                  w_state_nxt     = WR;
               end else begin
                  w_state_nxt = CMD;
               end
            end
         end
         WR: begin
            if (i_bus_ack) w_state_nxt = CMD;
            if (i_we)      w_err_set   = 1'b1;
         end
         default: w_state_nxt = CMD;
      endcase

      if (w_timeout) begin
         w_state_nxt = CMD;
         w_err_set   = 1'b1;
      end

      w_err_nxt = w_err_set | (r_err & ~w_err_clr);

      if (w_state_nxt != r_state || r_state == CMD) w_cnt_nxt = '0;
      else                                          w_cnt_nxt = r_cnt + 1'b1;
   end

   assign o_di        = (r_state == CMD) ? {r_err, {(size-1){1'b0}}} : r_tx;
   assign o_bus_addr  = r_bus_addr;
   assign o_bus_wdata = r_bus_wdata;
   assign o_bus_rd    = (r_state == RD);
   assign o_bus_wr    = (r_state == WR);
   assign o_err       = r_err;

endmodule

// File: tb/tb_spi_bridge.sv
// Directed bench for spi_bridge: write, read, late read, timeout and mid-write reset.
module tb_spi_bridge;

   logic       clk;
   logic       nrst;
   logic       re;
   logic       we;
   logic [7:0] tb_do;
   logic [7:0] di;
   logic [6:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_rd;
   logic       bus_wr;
   logic [7:0] bus_rdata;
   logic       bus_ack;
   logic       err;

   int checks   = 0;
   int failures = 0;

   spi_bridge #(.size(8), .timeout(16)) dut (
      .i_clk       (clk),
      .i_nrst      (nrst),
      .i_re        (re),
      .i_we        (we),
      .i_do        (tb_do),
      .o_di        (di),
      .o_bus_addr  (bus_addr),
      .o_bus_wdata (bus_wdata),
      .o_bus_rd    (bus_rd),
      .o_bus_wr    (bus_wr),
      .i_bus_rdata (bus_rdata),
      .i_bus_ack   (bus_ack),
      .o_err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SPI frame: re pulse (di captured as spi would), shift time, then we pulse with the word.
   task automatic frame(input logic [7:0] word, output logic [7:0] shifted);
      re      = 1'b1;
      shifted = di;
      @(negedge clk);
      re = 1'b0;
      tick(3);
      tb_do = word;
      we    = 1'b1;
      @(negedge clk);
      we    = 1'b0;
      tb_do = 8'h00;
   endtask

   logic [7:0] sh;

   initial begin
      nrst      = 1'b0;
      re        = 1'b0;
      we        = 1'b0;
      tb_do     = 8'h00;
      bus_rdata = 8'h00;
      bus_ack   = 1'b0;
      tick(2);
      chk("rst_di",    {8'h0, di},        16'h0000);
      chk("rst_addr",  {9'h0, bus_addr},  16'h0000);
      chk("rst_wdata", {8'h0, bus_wdata}, 16'h0000);
      chk("rst_rd",    {15'h0, bus_rd},   16'h0000);
      chk("rst_wr",    {15'h0, bus_wr},   16'h0000);
      chk("rst_err",   {15'h0, err},      16'h0000);
      nrst = 1'b1;
      tick(2);

      // Write 0x3C to address 0x05
      frame(8'h85, sh);
      chk("wr_cmd_shift", {8'h0, sh}, 16'h0000);
      chk("wr_no_rd", {15'h0, bus_rd}, 16'h0000);
      frame(8'h3C, sh);
      chk("wr_data_shift", {8'h0, sh}, 16'h0000);
      chk("wr_req",   {15'h0, bus_wr},   16'h0001);
      chk("wr_addr",  {9'h0, bus_addr},  16'h0005);
      chk("wr_wdata", {8'h0, bus_wdata}, 16'h003C);
      tick(2);
      chk("wr_held", {15'h0, bus_wr}, 16'h0001);
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("wr_done",   {15'h0, bus_wr}, 16'h0000);
      chk("wr_err",    {15'h0, err},    16'h0000);
      chk("wr_cmd_di", {8'h0, di},      16'h0000);

      // Read address 0x12 returning 0xA7
      frame(8'h12, sh);
      chk("rd_req",  {15'h0, bus_rd},  16'h0001);
      chk("rd_addr", {9'h0, bus_addr}, 16'h0012);
      chk("rd_no_wr", {15'h0, bus_wr}, 16'h0000);
      tick(1);
      bus_rdata = 8'hA7;
      bus_ack   = 1'b1;
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = 8'h00;
      chk("rd_drop", {15'h0, bus_rd}, 16'h0000);
      frame(8'hFF, sh);
      chk("rd_data_shift", {8'h0, sh}, 16'h00A7);

      // Late read: data frame starts before any ack
      frame(8'h12, sh);
      chk("late_cmd_shift", {8'h0, sh}, 16'h0000);
      chk("late_req", {15'h0, bus_rd}, 16'h0001);
      re = 1'b1;
      sh = di;
      @(negedge clk);
      re = 1'b0;
      chk("late_data_shift", {8'h0, sh}, 16'h0000);
      chk("late_rd_drop", {15'h0, bus_rd}, 16'h0000);
      chk("late_err", {15'h0, err}, 16'h0001);
      tick(3);
      we = 1'b1;
      tb_do = 8'h55;
      @(negedge clk);
      we = 1'b0;
      tb_do = 8'h00;
      chk("late_di_err", {8'h0, di}, 16'h0080);

      // Timeout: write command with no data frame
      frame(8'h85, sh);
      chk("to_cmd_shift", {8'h0, sh}, 16'h0080);
      chk("to_err_clr", {15'h0, err}, 16'h0000);
      tick(15);
      chk("to_before", {15'h0, err}, 16'h0000);
      tick(1);
      chk("to_err", {15'h0, err}, 16'h0001);
      chk("to_di", {8'h0, di}, 16'h0080);

      // Reset while a write is pending
      frame(8'h85, sh);
      chk("rs_cmd_shift", {8'h0, sh}, 16'h0080);
      frame(8'h3C, sh);
      chk("rs_wr_req", {15'h0, bus_wr}, 16'h0001);
      #3 nrst = 1'b0;
      #1;
      chk("rs_wr",    {15'h0, bus_wr},   16'h0000);
      chk("rs_rd",    {15'h0, bus_rd},   16'h0000);
      chk("rs_addr",  {9'h0, bus_addr},  16'h0000);
      chk("rs_wdata", {8'h0, bus_wdata}, 16'h0000);
      chk("rs_di",    {8'h0, di},        16'h0000);
      chk("rs_err",   {15'h0, err},      16'h0000);
      @(negedge clk);
      nrst = 1'b1;
      tick(1);

      // Read address 0x01 after reset
      frame(8'h01, sh);
      chk("ar_cmd_shift", {8'h0, sh}, 16'h0000);
      chk("ar_req",  {15'h0, bus_rd},  16'h0001);
      chk("ar_addr", {9'h0, bus_addr}, 16'h0001);
      bus_rdata = 8'h5A;
      bus_ack   = 1'b1;
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = 8'h00;
      frame(8'h00, sh);
      chk("ar_data_shift", {8'h0, sh}, 16'h005A);
      chk("ar_err", {15'h0, err}, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
